// File: rtl/gf2m_serial_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier, MSB-first, D bits of op_b per clock.
// Product is held in result until the next operation completes or reset.
module gf2m_serial_mult #(
    parameter int unsigned M = 163,
    parameter int unsigned D = 1,
    parameter logic [M-1:0] IRR = 163'hC9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] op_a,
    input  logic [M-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] result
);

    localparam int unsigned N  = (M + D - 1) / D;
    localparam int unsigned PW = N * D;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            load_c;
    logic            step_c;
    logic            last_c;

    logic [M-1:0]    a_r;
    logic [PW-1:0]   b_r;
    logic [M-1:0]    acc;
    logic [CW-1:0]   cnt;

    logic [M-1:0]    acc_nx;
    logic [PW-1:0]   b_nx;
    logic [M-1:0]    step_t;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath control strobes
    always_comb begin
        state_nx = state;
        load_c   = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_c   = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_c   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // D unrolled shift-reduce-add steps; reduction uses the pre-shift MSB of acc
    always_comb begin
        acc_nx = acc;
        b_nx   = b_r;
        step_t = '0;
        for (int i = 0; i < int'(D); i++) begin
            step_t = {acc_nx[M-2:0], 1'b0};
            if (acc_nx[M-1]) begin
                step_t = step_t ^ IRR;
            end
            if (b_nx[PW-1]) begin
                step_t = step_t ^ a_r;
            end
            acc_nx = step_t;
            b_nx   = {b_nx[PW-2:0], 1'b0};
        end
    end

    // Operand latch, accumulator, digit counter and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (load_c) begin
            a_r <= op_a;
            b_r <= PW'(op_b);
            acc <= '0;
            cnt <= '0;
        end else if (step_c) begin
            acc <= acc_nx;
            b_r <= b_nx;
            cnt <= cnt + CW'(1);
            if (last_c) begin
                result <= acc_nx;
            end
        end
    end

    // Registered status flags, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == S_RUN);
            done <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_gf2m_serial_mult.sv
// Directed bench for gf2m_serial_mult: D=1 and D=4 instances run side by side.
module tb_gf2m_serial_mult;

    localparam int unsigned M  = 163;
    localparam int unsigned N1 = 163;
    localparam int unsigned N4 = 41;
    localparam logic [M-1:0] IRR = 163'hC9;

    logic         clk;
    logic         rst;
    logic         start1, start4;
    logic [M-1:0] op_a1, op_b1, op_a4, op_b4;
    logic         busy1, done1, busy4, done4;
    logic [M-1:0] result1, result4;

    int errors;
    int checks;

    gf2m_serial_mult #(.M(M), .D(1), .IRR(IRR)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
        .busy(busy1), .done(done1), .result(result1)
    );

    gf2m_serial_mult #(.M(M), .D(4), .IRR(IRR)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_a(op_a4), .op_b(op_b4),
        .busy(busy4), .done(done4), .result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LSB-first reference multiply: r += b[i] * (a * x^i mod f)
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] s;
        r = '0;
        s = a;
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) r = r ^ s;
            s = s[M-1] ? ({s[M-2:0], 1'b0} ^ IRR) : {s[M-2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [M-1:0] rnd();
        return M'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start both instances on the same edge; latency counted from the accepting edge
    task automatic run_both(input logic [M-1:0] a1, input logic [M-1:0] b1,
                            input logic [M-1:0] a4, input logic [M-1:0] b4,
                            output logic [M-1:0] r1, output logic [M-1:0] r4,
                            output int lat1, output int lat4);
        int cyc;
        bit got1, got4;
        r1 = '0; r4 = '0; lat1 = 0; lat4 = 0;
        got1 = 0; got4 = 0; cyc = 0;
        @(posedge clk); #1;
        op_a1 = a1; op_b1 = b1; op_a4 = a4; op_b4 = b4;
        start1 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        while (!(got1 && got4) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (!got1 && done1) begin got1 = 1; lat1 = cyc; r1 = result1; end
            if (!got4 && done4) begin got4 = 1; lat4 = cyc; r4 = result4; end
        end
    endtask

    logic [M-1:0] x162, a, b, r1, r4, exp_p;
    int lat1, lat4;
    int busy_cnt, done_cnt;
    int t1[2], t4[2];
    int n1, n4;

    initial begin
        errors = 0; checks = 0;
        rst = 1'b0; start1 = 1'b0; start4 = 1'b0;
        op_a1 = '0; op_b1 = '0; op_a4 = '0; op_b4 = '0;
        x162 = '0;
        x162[162] = 1'b1;

        // Test 1: reset state, then identity with latency check
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_d1", M'(busy1), '0);
        check("rst_done_d1", M'(done1), '0);
        check("rst_result_d1", result1, '0);
        check("rst_busy_d4", M'(busy4), '0);
        check("rst_result_d4", result4, '0);
        rst = 1'b1;
        run_both(M'(1), M'(1), M'(1), M'(1), r1, r4, lat1, lat4);
        check("ident_lat_d1", M'(lat1), M'(N1));
        check("ident_res_d1", r1, M'(1));
        check("ident_lat_d4", M'(lat4), M'(N4));
        check("ident_res_d4", r4, M'(1));

        // Test 2: reduction wrap
        run_both(x162, M'(2), x162, M'(2), r1, r4, lat1, lat4);
        check("wrap2_d1", r1, M'(16'h00C9));
        check("wrap2_d4", r4, M'(16'h00C9));
        check("wrap2_lat_d4", M'(lat4), M'(N4));
        run_both(x162, M'(4), x162, M'(4), r1, r4, lat1, lat4);
        check("wrap4_d1", r1, M'(16'h0192));
        check("wrap4_d4", r4, M'(16'h0192));

        // Test 3: zero operand, then commutativity against the model
        b = rnd();
        run_both('0, b, '0, b, r1, r4, lat1, lat4);
        check("zero_d1", r1, '0);
        check("zero_d4", r4, '0);
        for (int i = 0; i < 200; i++) begin
            a = rnd();
            b = rnd();
            exp_p = gf_mul(a, b);
            run_both(a, b, b, a, r1, r4, lat1, lat4);
            check("rand_ab_d1", r1, exp_p);
            check("rand_ba_d4", r4, exp_p);
            check("rand_lat_d1", M'(lat1), M'(N1));
            check("rand_lat_d4", M'(lat4), M'(N4));
        end

        // Test 4: operand changes and start pulses during RUN are ignored
        a = rnd();
        b = rnd();
        exp_p = gf_mul(a, b);
        @(posedge clk); #1;
        op_a1 = a; op_b1 = b; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < int'(N1) + 10; i++) begin
            if (busy1) busy_cnt++;
            if (done1) done_cnt++;
            if (i == 5) begin op_a1 = rnd(); op_b1 = rnd(); start1 = 1'b1; end
            if (i == 6) start1 = 1'b0;
            @(posedge clk); #1;
        end
        check("prot_busy_cycles", M'(busy_cnt), M'(N1));
        check("prot_done_pulses", M'(done_cnt), M'(1));
        check("prot_result", result1, exp_p);

        // Test 5: reset in the middle of RUN clears everything
        @(posedge clk); #1;
        op_a1 = rnd(); op_b1 = rnd(); start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        check("midrun_busy_before", M'(busy1), M'(1));
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrun_busy", M'(busy1), '0);
        check("midrun_done", M'(done1), '0);
        check("midrun_result", result1, '0);
        rst = 1'b1;
        run_both(x162, M'(2), x162, M'(2), r1, r4, lat1, lat4);
        check("post_rst_res_d1", r1, M'(16'h00C9));
        check("post_rst_lat_d1", M'(lat1), M'(N1));

        // Test 6: held start gives an N+2 issue period
        @(posedge clk); #1;
        op_a1 = x162; op_b1 = M'(2); op_a4 = x162; op_b4 = M'(2);
        start1 = 1'b1; start4 = 1'b1;
        n1 = 0; n4 = 0;
        t1[0] = 0; t1[1] = 0; t4[0] = 0; t4[1] = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (done1 && n1 < 2) begin t1[n1] = c; n1++; end
            if (done4 && n4 < 2) begin t4[n4] = c; n4++; end
        end
        start1 = 1'b0; start4 = 1'b0;
        check("period_d1", M'(t1[1] - t1[0]), M'(N1 + 2));
        check("period_d4", M'(t4[1] - t4[0]), M'(N4 + 2));
        check("period_res_d4", result4, M'(16'h00C9));
        repeat (N1 + 4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf2m_serial_mult.md
Name: gf2m_serial_mult

Overview:
- Digit-serial multiplier over GF(2^163) in polynomial basis, reduced by f(x) = x^163 + x^7 + x^6 + x^3 + 1.
- Sits directly downstream of the LA register-loader FSM.
  - Operands come from the loaded 163-bit operand registers.
  - `start` is driven by the loader's processing-state enable.
  - `done` returns to the loader as its slave-done.
- Holds the product until the loader reads it out.

Parameters:
- M, 163, field degree and operand/result width.
- D, 1, digit size: bits of op_b consumed per clock. Legal range 1..8.
- IRR, 163'h00000000000000000000000000000000000000C9, f(x) with the x^M term removed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; 0 = reset, sampled on the rising edge of clk.
- start  input  1  request a multiply. Sampled only in IDLE.
- op_a  input  M  multiplicand a(x); bit i is the coefficient of x^i.
- op_b  input  M  multiplier b(x); same bit ordering.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- result  output  M  a(x)·b(x) mod f(x).

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, busy=0, done=0, result=0, internal acc/cnt/operand registers = 0. Reset takes priority over everything, including mid-RUN.
- Constant N = ceil(M/D): 163 for D=1, 41 for D=4.
- op_b is zero-extended at the MSB end to N·D bits. Leading zero digits contribute nothing.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at edge t0: latch a_r=op_a, b_r=padded op_b, acc=0, cnt=0, go to RUN.
  - op_a/op_b are not sampled after t0.
- RUN (busy=1): at each edge, perform D unrolled single-bit steps, MSB-first from b_r, in this order for each step:
  1. t = acc<<1 over M bits.
  2. If acc[M-1]=1, t ^= IRR.
  3. If the current top bit of b_r is 1, t ^= a_r.
  4. acc = t; b_r shifts left by one.
- RUN counting:
  - cnt increments once per edge.
  - On the edge where cnt reaches N-1, acc's final value is written directly to result and the state goes to DONE.
  - This is RUN edges t0+1 … t0+N.
- DONE: done=1, busy=0 for exactly one cycle (the cycle after edge t0+N). Next edge goes to IDLE.
- Latency: done is visible N cycles after the edge that accepted start.
- start handling:
  - start in RUN or DONE is ignored; no queuing.
  - A held-high start re-triggers on the first IDLE edge, which gives an N+2-cycle issue period.
- Operand stability: changing op_a/op_b during RUN has no effect on the in-flight result.
- result register:
  - Updated only on the final RUN edge.
  - Holds its value through IDLE and during the next RUN until that operation completes.
  - Cleared only by reset.
- Reset mid-RUN: the operation is aborted and result is cleared to 0. The first start after reset deasserts behaves normally.
- All arithmetic is carry-less (XOR). No integer carries anywhere.
- cnt width: ceil(log2(N+1)) bits.

Test Plan:
1. Reset then identity: rst=0 for 2 cycles; expect busy=done=0, result=0. Then op_a=1, op_b=1, start for 1 cycle; expect done exactly 163 cycles after the start edge (D=1) and result=1.
2. Reduction wrap: op_a=x^162 (bit 162 set only), op_b=2 → result=0xC9. With op_b=4 → result=0x192 (x^8+x^7+x^4+x).
3. Zero/commutativity: op_a=0 with random op_b → result=0. Then 200 random pairs (a,b) and (b,a) → both results equal, and equal to the bench's software GF(2^163) model.
4. Busy protection: start a multiply, then during RUN change op_a/op_b and pulse start again; expect a single done pulse and a result equal to the product of the originally latched operands. busy stays high for exactly N cycles.
5. Mid-run reset: drive rst=0 at RUN cycle 80; expect state IDLE, busy=0, done=0, result=0 the next cycle. A new start with (x^162, 2) then completes normally with 0xC9.
6. Digit size: rebuild with D=4 and rerun tests 2–3; expect done 41 cycles after the start edge and identical results. Hold start high continuously and check the issue period is N+2 = 43 cycles.
